load_store_unit: RTL
====================

# load_store_unit

Initiator side of the byte-addressed 64 KiB data memory port, which has an 8-bit write mask, a 16-bit address, 64-bit write data and 64-bit combinational read data. The unit accepts one load or store at a time from the pipeline's MEM stage over a valid/ready handshake. It decodes funct3 into the memory write mask, drives the memory port for exactly one cycle, and sign- or zero-extends load data. It returns a registered response with an access-fault flag.

## Interface
- No parameters. Data width is 64 bits (DEF::dw); memory address width is 16 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64I load/store funct3.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  64  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access fault; no memory side effect occurred.
- mem_w_mask  out  8  memory write mask.
- mem_address  out  16  memory byte address.
- mem_write_data  out  64  memory write data.
- mem_read_data  in  64  memory read data, combinational on mem_address.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Accept condition: req_valid && req_ready.
  - Latches we, funct3, req_addr[15:0] and req_wdata.
  - Latches fault = (req_addr[63:16] != 0) || illegal funct3.
- Illegal funct3 for loads: 3'b111.
- Illegal funct3 for stores: any funct3 with bit 2 set.
- Transitions:
  - IDLE -> ACCESS on accept.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE on rsp_ready when there is no accept.
  - RESP -> ACCESS on rsp_ready together with an accept.
- req_ready = (state == IDLE) || (state == RESP && rsp_ready).
- rsp_valid = (state == RESP).
- mem_address and mem_write_data are driven from the latched address and data in every state.
- mem_w_mask is nonzero only in ACCESS, for a store that is not faulting:
  - SB (000) -> 8'h01.
  - SH (001) -> 8'h03.
  - SW (010) -> 8'h0F.
  - SD (011) -> 8'hFF.
- mem_w_mask is 8'h00 in all other cases.
- mem_write_data = latched req_wdata, unshifted; the memory consumes the low bytes.
- Loads: mem_read_data is sampled at the end of the ACCESS cycle and extended into the rsp_rdata register:
  - LB (000): sign-extend byte [7:0].
  - LH (001): sign-extend half [15:0].
  - LW (010): sign-extend word [31:0].
  - LD (011): full 64 bits.
  - LBU (100), LHU (101), LWU (110): zero-extend.
- Faulting request:
  - Still passes through ACCESS, with mem_w_mask = 0.
  - In RESP: rsp_fault = 1 and rsp_rdata = 0.
- Store response: rsp_fault = 0 and rsp_rdata = 0.
- Misaligned addresses are legal. Accesses running past 0xFFFF wrap within the 16-bit address space; this is memory behaviour, not a fault.
- Response outputs are held stable while rsp_valid && !rsp_ready.

## Timing
- Accept at edge N -> ACCESS during cycle N..N+1 -> the memory write commits at edge N+1 -> rsp_valid from edge N+1.
- Load-to-response latency is 1 cycle after accept.
- Minimum issue interval is 2 cycles: back-to-back requests are possible when rsp_ready is held high.
- mem_w_mask is high for exactly one clock per store, so there are no duplicate writes during response stalls.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - mem_w_mask = 0 immediately.
  - mem_address = 0 and mem_write_data = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0.
  - req_ready = 1 while in IDLE after reset release.
- Reset asserted during ACCESS aborts the access: the mask drops asynchronously, so no write occurs at the following edge. No response is produced.
- A new request is never accepted in ACCESS: req_ready = 0 there.

## Test plan
- SD addr 0x0010, data 0x8877665544332211, then LD 0x0010:
  - mem_w_mask = 8'hFF for one cycle.
  - rsp_rdata = 0x8877665544332211, rsp_fault = 0.
- SB data 0x80 at 0x0020, then:
  - LB 0x0020 -> rsp_rdata = 0xFFFFFFFFFFFFFF80.
  - LBU 0x0020 -> rsp_rdata = 0x0000000000000080.
- LW/LWU at 0x0013 over stored word 0x80000001 -> 0xFFFFFFFF80000001 and 0x0000000080000001 respectively. Covers misaligned access.
- Store to 0x0000000000010000, and load with funct3 111:
  - rsp_fault = 1, rsp_rdata = 0.
  - mem_w_mask stays 0 throughout; prior memory contents unchanged.
- Two stores back-to-back with rsp_ready stalled low for 3 cycles after the first:
  - The first rsp holds stable.
  - req_ready = 0 during the stall.
  - Exactly one mask pulse per store.
  - The second is accepted on the cycle rsp_ready rises.
- SH issued, with rst_n pulsed low during ACCESS:
  - mem_w_mask = 0 immediately and the memory byte stays unchanged.
  - rsp_valid = 0.
  - req_ready = 1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : single-outstanding load/store initiator for a 64 KiB
//                   byte-addressed data memory with a registered response.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [7:0]  mem_w_mask,
  output logic [15:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_fault;
  logic [DW-1:0]   r_rdata;
  logic            r_rsp_fault;
  logic            w_accept;
  logic            w_req_fault;
  logic [DW-1:0]   w_ext;
  logic [7:0]      w_mask;

  assign req_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_fault = r_rsp_fault;

  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_w_mask     = w_mask;

  // Out-of-range address or a funct3 with no encoding for the direction.
  assign w_req_fault = (req_addr[63:AW] != '0) ||
                       (req_we ? req_funct3[2] : (req_funct3 == 3'b111));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = w_accept ? ST_ACCESS : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Mask is purely combinational on state so an async reset kills it at once.
  always_comb begin
    w_mask = 8'h00;
    if ((r_state == ST_ACCESS) && r_we && !r_fault) begin
      case (r_funct3[1:0])
        2'b00:   w_mask = 8'h01;
        2'b01:   w_mask = 8'h03;
        2'b10:   w_mask = 8'h0F;
        default: w_mask = 8'hFF;
      endcase
    end
  end

  always_comb begin
    w_ext = '0;
    case (r_funct3)
      3'b000:  w_ext = {{56{mem_read_data[7]}},  mem_read_data[7:0]};
      3'b001:  w_ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  w_ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b011:  w_ext = mem_read_data;
      3'b100:  w_ext = {56'd0, mem_read_data[7:0]};
      3'b101:  w_ext = {48'd0, mem_read_data[15:0]};
      3'b110:  w_ext = {32'd0, mem_read_data[31:0]};
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[AW-1:0];
        r_wdata  <= req_wdata;
        r_fault  <= w_req_fault;
      end
      // Response registers only move at the end of ACCESS, so they hold in RESP.
      if (r_state == ST_ACCESS) begin
        r_rdata     <= (r_we || r_fault) ? '0 : w_ext;
        r_rsp_fault <= r_fault;
      end
    end
  end

endmodule

`default_nettype wire
